// File: rtl/astropix_frame_packer_pkg.sv
// Shared types and constants for the AstroPix lane frame packer.
// Package astropix_pkg: byte/word types, packer states, keep lookup.
package astropix_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DROP
    } pk_state_e;

    // Lane ID + frame header + 4 timestamp bytes around the data bytes
    localparam int FRAME_OVERHEAD_BYTES = 6;

    localparam logic [3:0] TKEEP_1 = 4'h1;
    localparam logic [3:0] TKEEP_2 = 4'h3;
    localparam logic [3:0] TKEEP_3 = 4'h7;
    localparam logic [3:0] TKEEP_4 = 4'hF;

    // Keep mask for a word whose last live byte sits in lane idx
    function automatic logic [3:0] tkeep_for(input logic [1:0] idx);
        unique case (idx)
            2'd0:    return TKEEP_1;
            2'd1:    return TKEEP_2;
            2'd2:    return TKEEP_3;
            default: return TKEEP_4;
        endcase
    endfunction

endpackage

// File: rtl/astropix_frame_packer_if.sv
// Byte-in / word-out AXI-stream bundle of the frame packer.
// master = byte source and word sink, slave = the packer.
interface astropix_frame_packer_if;
    import astropix_pkg::*;

    byte_t      s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    word_t      m_axis_tdata;
    logic [3:0] m_axis_tkeep;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep,
        output m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/astropix_byte_accumulator.sv
// Packs bytes into 32-bit little-endian words with pad fill and keep.
// Owns the output word register and the input-side ready.
module astropix_byte_accumulator
    import astropix_pkg::*;
#(
    parameter byte_t PAD_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  byte_t      byte_i,
    input  logic       close_i,
    input  logic       err_i,
    input  logic       out_ready_i,
    output logic       in_ready_o,
    output word_t      data_o,
    output logic [3:0] keep_o,
    output logic       valid_o,
    output logic       last_o,
    output logic       user_o
);

    byte_t [2:0] lane_q;
    logic [1:0]  idx_q;
    word_t       word_d;
    logic        emit;
    word_t       data_q;
    logic [3:0]  keep_q;
    logic        valid_q;
    logic        last_q;
    logic        user_q;

    assign emit       = push_i && (close_i || idx_q == 2'd3);
    assign in_ready_o = !valid_q || out_ready_i;

    // Assemble the outgoing word: stored lanes, current byte, then pad
    always_comb begin
        word_d = {4{PAD_BYTE}};
        for (int i = 0; i < 3; i++) begin
            if (i < int'(idx_q)) word_d[8*i +: 8] = lane_q[i];
        end
        word_d[{idx_q, 3'd0} +: 8] = byte_i;
    end

    // Lane index and partial-word storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            idx_q  <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            idx_q  <= '0;
        end else if (emit) begin
            idx_q <= '0;
        end else if (push_i) begin
            lane_q[idx_q] <= byte_i;
            idx_q         <= idx_q + 2'd1;
        end
    end

    // Output word register, held while the sink stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (clr_i) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (emit) begin
            data_q  <= word_d;
            keep_q  <= tkeep_for(idx_q);
            valid_q <= 1'b1;
            last_q  <= close_i;
            user_q  <= close_i && err_i;
        end else if (out_ready_i) begin
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign user_o  = user_q;

endmodule

// File: rtl/astropix_frame_packer.sv
// Frame length checker and word packer for one AstroPix lane.
// Define ASTROPIX_PACKER_STATS_EN to build the frame/error counters.
module astropix_frame_packer
    import astropix_pkg::*;
#(
    parameter int    MAX_FRAME_BYTES = 16,
    parameter byte_t PAD_BYTE        = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    astropix_frame_packer_if.slave bus,
    input  logic                   cfg_lane_reset,
    output logic                   stat_frame_done,
    output logic                   stat_frame_error,
    output logic [15:0]            stat_frames_count,
    output logic [15:0]            stat_errors_count
);

    localparam byte_t MAX_B = byte_t'(MAX_FRAME_BYTES);

    pk_state_e state_q, state_d;
    byte_t     len_q, len_d;
    byte_t     cnt_q, cnt_d;
    byte_t     cnt_inc;
    logic      acc;
    logic      push;
    logic      close;
    logic      err;
    logic      done_q;
    logic      error_q;

    assign acc     = bus.s_axis_tvalid && bus.s_axis_tready;
    assign cnt_inc = cnt_q + 8'd1;

    // Frame state machine: length check, truncation and drop
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        close   = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    push  = 1'b1;
                    len_d = bus.s_axis_tdata;
                    cnt_d = '0;
                    if (bus.s_axis_tlast) begin
                        close = 1'b1;
                        err   = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (acc) begin
                    push  = 1'b1;
                    cnt_d = cnt_inc;
                    if (bus.s_axis_tlast) begin
                        close   = 1'b1;
                        err     = cnt_inc != len_q;
                        state_d = IDLE;
                    end else if (cnt_inc == MAX_B) begin
                        close   = 1'b1;
                        err     = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (acc && bus.s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers and per-frame status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (cfg_lane_reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= close;
            error_q <= close && err;
        end
    end

    assign stat_frame_done  = done_q;
    assign stat_frame_error = error_q;

`ifdef ASTROPIX_PACKER_STATS_EN
    logic [15:0] frames_q;
    logic [15:0] errors_q;

    // Saturating closed-frame and error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q <= '0;
            errors_q <= '0;
        end else if (cfg_lane_reset) begin
            frames_q <= '0;
            errors_q <= '0;
        end else if (close) begin
            if (frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
            if (err && errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
        end
    end

    assign stat_frames_count = frames_q;
    assign stat_errors_count = errors_q;
`else
    assign stat_frames_count = '0;
    assign stat_errors_count = '0;
`endif

    astropix_byte_accumulator #(
        .PAD_BYTE(PAD_BYTE)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cfg_lane_reset),
        .push_i     (push),
        .byte_i     (bus.s_axis_tdata),
        .close_i    (close),
        .err_i      (err),
        .out_ready_i(bus.m_axis_tready),
        .in_ready_o (bus.s_axis_tready),
        .data_o     (bus.m_axis_tdata),
        .keep_o     (bus.m_axis_tkeep),
        .valid_o    (bus.m_axis_tvalid),
        .last_o     (bus.m_axis_tlast),
        .user_o     (bus.m_axis_tuser)
    );

endmodule

// File: tb/tb_astropix_frame_packer.sv
// Randomised, model-checked bench for astropix_frame_packer.
// Honours ASTROPIX_PACKER_STATS_EN for the counter expectations.
module tb_astropix_frame_packer;

    localparam int MAXB = 16;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_lane_reset = 1'b0;
    logic stat_frame_done, stat_frame_error;
    logic [15:0] stat_frames_count, stat_errors_count;

    astropix_frame_packer_if bus ();

    astropix_frame_packer dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cfg_lane_reset   (cfg_lane_reset),
        .stat_frame_done  (stat_frame_done),
        .stat_frame_error (stat_frame_error),
        .stat_frames_count(stat_frames_count),
        .stat_errors_count(stat_errors_count)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t obs_log[$];
    int   model_frames = 0, model_errs = 0;
    int   seen_done = 0, seen_err = 0;
    int   rmode = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference: which bytes survive, error flag, word split with pad
    function automatic void model_frame(input logic [7:0] fb[$],
                                        output exp_t w[$], output bit err);
        int n = fb.size();
        int kept;
        exp_t e;
        w = {};
        if (n - 1 > MAXB) begin
            kept = MAXB + 1;
            err  = 1'b1;
        end else begin
            kept = n;
            err  = (n == 1) || (n - 1 != int'(fb[0]));
        end
        for (int b = 0; b < kept; b += 4) begin
            e.d = {4{8'hFF}};
            e.k = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (b + j < kept) begin
                    e.d[8*j +: 8] = fb[b+j];
                    e.k[j] = 1'b1;
                end
            end
            e.l = (b + 4 >= kept);
            e.u = e.l && err;
            w.push_back(e);
        end
    endfunction

    function automatic int cnt_exp(input int v);
`ifdef ASTROPIX_PACKER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Downstream ready patterns
    logic [3:0] pat = 4'b1001;
    int ph = 0;
    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    bus.m_axis_tready = pat[3-ph];
                    ph = (ph + 1) % 4;
                end
                2: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
                default: bus.m_axis_tready = 1'b1;
            endcase
        end
    end

    // Per-cycle compare against the model queue
    bit   stalled_prev = 0;
    exp_t prev;
    always @(negedge clk) begin
        exp_t e, cur;
        if (rst || cfg_lane_reset) begin
            stalled_prev = 0;
        end else begin
            cur = '{bus.m_axis_tdata, bus.m_axis_tkeep,
                    bus.m_axis_tlast, bus.m_axis_tuser};
            chk("s_ready_rule", {31'd0, bus.s_axis_tready},
                {31'd0, !bus.m_axis_tvalid || bus.m_axis_tready});
            if (stalled_prev) begin
                chk("stall_valid", {31'd0, bus.m_axis_tvalid}, 32'd1);
                chk("stall_word", cur, prev);
            end
            if (!bus.m_axis_tvalid && bus.m_axis_tuser)
                chk("tuser_idle", {31'd0, bus.m_axis_tuser}, 32'd0);
            if (stat_frame_done) begin
                seen_done++;
                chk("done_on_last",
                    {31'd0, bus.m_axis_tvalid && bus.m_axis_tlast}, 32'd1);
                chk("error_eq_user", {31'd0, stat_frame_error},
                    {31'd0, bus.m_axis_tuser});
            end
            if (stat_frame_error) seen_err++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", cur[31:0], 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", cur.d, e.d);
                    chk("word_keep", {28'd0, cur.k}, {28'd0, e.k});
                    chk("word_last", {31'd0, cur.l}, {31'd0, e.l});
                    chk("word_user", {31'd0, cur.u}, {31'd0, e.u});
                end
                obs_log.push_back(cur);
            end
            stalled_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev = cur;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last);
        int  t = 0;
        bit  ok;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.s_axis_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 500);
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input bit gaps);
        exp_t w[$];
        bit   err;
        model_frame(fb, w, err);
        foreach (w[i]) exp_q.push_back(w[i]);
        model_frames++;
        if (err) model_errs++;
        foreach (fb[i]) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            send_byte(fb[i], i == fb.size() - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_done_pulses"}, seen_done, model_frames);
        chk({tag, "_err_pulses"}, seen_err, model_errs);
        chk({tag, "_frames_cnt"}, {16'd0, stat_frames_count},
            cnt_exp(model_frames));
        chk({tag, "_errors_cnt"}, {16'd0, stat_errors_count},
            cnt_exp(model_errs));
    endtask

    task automatic mid_reset(input bit use_cfg);
        send_byte(8'h06, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        if (use_cfg) begin
            cfg_lane_reset = 1'b1;
            @(posedge clk);
            #1;
            cfg_lane_reset = 1'b0;
        end else begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        model_frames = 0;
        model_errs   = 0;
        seen_done    = 0;
        seen_err     = 0;
        @(negedge clk);
        chk("rst_mvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
        check_stats("after_rst");
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1[$] = '{8'h07, 8'h03, 8'hA1, 8'h11, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic [7:0] t2[$] = '{8'h06, 8'h01, 8'h20, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    logic [7:0] t3[$] = '{8'h07, 8'h03, 8'hA1};

    initial begin
        logic [7:0] fb[$];
        exp_t w[$];
        bit   err;
        int   base, L, n;

        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
        chk("rst_tdata", bus.m_axis_tdata, 32'd0);
        chk("rst_tkeep", {28'd0, bus.m_axis_tkeep}, 32'd0);
        chk("rst_tlast_user", {30'd0, bus.m_axis_tlast, bus.m_axis_tuser}, 32'd0);
        chk("rst_stat", {14'd0, stat_frame_done, stat_frame_error,
                         stat_frames_count | stat_errors_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        model_frame(t1, w, err);
        chk("model_t1_n", w.size(), 2);
        chk("model_t1_w0", w[0].d, 32'h11A10307);
        chk("model_t1_w1", w[1].d, 32'hB3B2B1B0);
        chk("model_t1_err", {31'd0, err}, 32'd0);
        model_frame(t2, w, err);
        chk("model_t2_w1", w[1].d, 32'hFFC3C2C1);
        chk("model_t2_k1", {28'd0, w[1].k}, 32'h7);

        base = obs_log.size();
        send_frame(t1, 1'b0);
        drain();
        chk("t1_w0", obs_log[base].d, 32'h11A10307);
        chk("t1_w1", obs_log[base+1].d, 32'hB3B2B1B0);
        chk("t1_flags", {25'd0, obs_log[base].k, obs_log[base+1].k[0],
                         obs_log[base].l, obs_log[base+1].l,
                         obs_log[base+1].u}, {25'd0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0});
        check_stats("t1");

        base = obs_log.size();
        send_frame(t2, 1'b0);
        drain();
        chk("t2_w0", obs_log[base].d, 32'hC0200106);
        chk("t2_w1", obs_log[base+1].d, 32'hFFC3C2C1);
        chk("t2_k1", {28'd0, obs_log[base+1].k}, 32'h7);

        base = obs_log.size();
        send_frame(t3, 1'b0);
        drain();
        chk("t3_w0", obs_log[base].d, 32'hFFA10307);
        chk("t3_lu", {30'd0, obs_log[base].l, obs_log[base].u}, 32'h3);
        chk("t3_errors_cnt", {16'd0, stat_errors_count}, cnt_exp(1));
        check_stats("t3");

        fb = '{8'h20};
        for (int i = 1; i < 20; i++) fb.push_back(8'($urandom));
        base = obs_log.size();
        send_frame(fb, 1'b0);
        drain();
        chk("t4_words", obs_log.size() - base, 5);
        chk("t4_last", {27'd0, obs_log[base+4].k, obs_log[base+4].u},
            {27'd0, 4'h1, 1'b1});
        send_frame(t1, 1'b0);
        drain();
        check_stats("t4");

        rmode = 1;
        base  = obs_log.size();
        send_frame(t1, 1'b0);
        drain();
        chk("t5_w0", obs_log[base].d, 32'h11A10307);
        chk("t5_w1", obs_log[base+1].d, 32'hB3B2B1B0);
        rmode = 0;
        drain();

        mid_reset(1'b0);
        send_frame(t2, 1'b0);
        drain();
        check_stats("t6");

        rmode = 2;
        for (int f = 0; f < 60; f++) begin
            L = $urandom_range(0, 20);
            case ($urandom_range(0, 3))
                0:       n = L;
                1:       n = L + 1;
                2:       n = (L > 0) ? L - 1 : 0;
                default: n = $urandom_range(0, 22);
            endcase
            fb = '{8'(L)};
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            send_frame(fb, 1'b1);
        end
        drain();
        check_stats("rand");

        rmode = 0;
        drain();
        mid_reset(1'b1);
        send_frame(t3, 1'b0);
        drain();
        check_stats("cfg_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
